// File: rtl/riscv_pkg.sv
// Shared opcode/funct3 constants and ALU operation encoding for the RV32I-subset core.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  // alt selects SUB/SRA; caller decides when funct7[5] is meaningful
  function automatic alu_op_e decode_alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational 32-bit ALU; zero flag feeds the branch decision.
module riscv_alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     alu_op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << b[4:0];
      ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'b0, a < b};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/riscv_processor.sv
// Single-cycle RV32I-subset core: external instruction memory, internal register file and data memory.
module riscv_processor
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  output logic [31:0] PC_out,
  output logic [31:0] ALUResult_out,
  output logic [31:0] Mem_ReadData_out
);

  localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q = RESET_PC;
  logic [31:0] pc_d;
  logic [31:0] rf_q [32] = '{default: '0};
  logic [31:0] dmem_q [DMEM_WORDS];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data, alu_a, alu_b, alu_result, wb_data;
  alu_op_e     alu_op;
  logic        alu_zero, valid, rf_we, dmem_we, wb_load, is_branch, is_jal, br_taken;
  logic [DMEM_AW-1:0] dmem_idx;

  assign opcode = Instruction[6:0];
  assign rd     = Instruction[11:7];
  assign funct3 = Instruction[14:12];
  assign rs1    = Instruction[19:15];
  assign rs2    = Instruction[24:20];

  assign imm_i = {{20{Instruction[31]}}, Instruction[31:20]};
  assign imm_s = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
  assign imm_b = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                  Instruction[30:25], Instruction[11:8], 1'b0};
  assign imm_u = {Instruction[31:12], 12'b0};
  assign imm_j = {{11{Instruction[31]}}, Instruction[31], Instruction[19:12],
                  Instruction[20], Instruction[30:21], 1'b0};

  assign rs1_data = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_data = (rs2 == '0) ? '0 : rf_q[rs2];

  always_comb begin
    alu_a     = rs1_data;
    alu_b     = rs2_data;
    alu_op    = ALU_ADD;
    valid     = 1'b0;
    rf_we     = 1'b0;
    dmem_we   = 1'b0;
    wb_load   = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        valid  = 1'b1;
        rf_we  = 1'b1;
        alu_b  = imm_u;
        alu_op = ALU_PASSB;
      end
      OPC_OPIMM: begin
        valid  = 1'b1;
        rf_we  = 1'b1;
        alu_b  = imm_i;
        // only SRAI uses funct7[5]; ADDI with a negative immediate must stay ADD
        alu_op = decode_alu_op(funct3, (funct3 == F3_SRL_SRA) && Instruction[30]);
      end
      OPC_OP: begin
        valid  = 1'b1;
        rf_we  = 1'b1;
        alu_op = decode_alu_op(funct3, Instruction[30]);
      end
      OPC_LOAD: if (funct3 == F3_LW) begin
        valid   = 1'b1;
        rf_we   = 1'b1;
        wb_load = 1'b1;
        alu_b   = imm_i;
      end
      OPC_STORE: if (funct3 == F3_SW) begin
        valid   = 1'b1;
        dmem_we = 1'b1;
        alu_b   = imm_s;
      end
      OPC_BRANCH: begin
        valid     = 1'b1;
        is_branch = 1'b1;
        alu_op    = ALU_SUB;
      end
      OPC_JAL: begin
        valid  = 1'b1;
        rf_we  = 1'b1;
        is_jal = 1'b1;
        alu_a  = pc_q;
        alu_b  = 32'd4;
      end
      default: ;
    endcase
  end

  riscv_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign br_taken = is_branch && (((funct3 == F3_BEQ) && alu_zero) ||
                                  ((funct3 == F3_BNE) && !alu_zero));

  assign ALUResult_out    = valid ? alu_result : '0;
  assign dmem_idx         = ALUResult_out[DMEM_AW+1:2];
  assign Mem_ReadData_out = dmem_q[dmem_idx];
  assign wb_data          = wb_load ? Mem_ReadData_out : ALUResult_out;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (br_taken)    pc_d = pc_q + imm_b;
    else if (is_jal) pc_d = pc_q + imm_j;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (!reset && rf_we && (rd != '0)) rf_q[rd] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && dmem_we) dmem_q[dmem_idx] <= rs2_data;
  end

  assign PC_out = pc_q;

endmodule

// File: tb/tb_riscv_processor.sv
// Self-checking bench for riscv_processor: per-cycle expected PC/ALU/memory values queued and drained.
module tb_riscv_processor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instruction;
  logic [31:0] PC_out, ALUResult_out, Mem_ReadData_out;

  logic [31:0] imem [64];
  logic [31:0] prog [$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic        chk_mem;
    logic [31:0] mem;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   failures = 0;

  riscv_processor #(.RESET_PC(32'h0000_0000), .DMEM_WORDS(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .Instruction      (Instruction),
    .PC_out           (PC_out),
    .ALUResult_out    (ALUResult_out),
    .Mem_ReadData_out (Mem_ReadData_out)
  );

  always #5 clk = ~clk;
  assign Instruction = imem[PC_out[7:2]];

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
  endtask

  function automatic void push(input logic [31:0] pc, input logic [31:0] alu);
    exp_q.push_back('{pc: pc, alu: alu, chk_mem: 1'b0, mem: '0});
  endfunction

  function automatic void push_m(input logic [31:0] pc, input logic [31:0] alu,
                                 input logic [31:0] mem);
    exp_q.push_back('{pc: pc, alu: alu, chk_mem: 1'b1, mem: mem});
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs from time 0 without any reset: PC must start at 0.
  task automatic test_power_up();
    int n;
    prog = '{32'hABCDE2B7, 32'h00001337, 32'hFFFFF3B7, 32'h12328293, 32'h00130313, 32'hFFF38393};
    load_prog();
    push(32'h00, 32'hABCDE000); push(32'h04, 32'h00001000); push(32'h08, 32'hFFFFF000);
    push(32'h0C, 32'hABCDE123); push(32'h10, 32'h00001001); push(32'h14, 32'hFFFFEFFF);
    #1;
    n = 0;
    while (exp_q.size() != 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (PC_out !== e.pc) begin
        failures++; $display("FAIL power_up_pc[%0d] got=%h exp=%h", n, PC_out, e.pc);
      end
      checks++;
      if (ALUResult_out !== e.alu) begin
        failures++; $display("FAIL power_up_alu[%0d] got=%h exp=%h", n, ALUResult_out, e.alu);
      end
      n++;
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    prog = '{addi(1, 0, 32'h11), addi(2, 0, 32'h22), addi(3, 0, 32'h33),
             addi(5, 0, 32'h5A), addi(5, 0, 32'h7F)};
    load_prog();
    @(negedge clk);
    apply_reset();
    push(32'h00, 32'h11); push(32'h04, 32'h22); push(32'h08, 32'h33);
    push(32'h0C, 32'h5A); push(32'h10, 32'h7F);
    n = 0;
    while (exp_q.size() != 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (PC_out !== e.pc) begin
        failures++; $display("FAIL reset_pre_pc[%0d] got=%h exp=%h", n, PC_out, e.pc);
      end
      checks++;
      if (ALUResult_out !== e.alu) begin
        failures++; $display("FAIL reset_pre_alu[%0d] got=%h exp=%h", n, ALUResult_out, e.alu);
      end
      n++;
      if (exp_q.size() != 0) @(negedge clk);
    end
    // reset coincides with the write of x5 <= 0x7F at PC 0x10
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    prog = '{enc_r(7'h00, 0, 1, 3'b000, 6), enc_r(7'h00, 0, 5, 3'b000, 7),
             enc_r(7'h00, 0, 2, 3'b000, 8)};
    load_prog();
    @(negedge clk);
    push(32'h00, 32'h11); push(32'h04, 32'h5A); push(32'h08, 32'h22);
    n = 0;
    while (exp_q.size() != 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (PC_out !== e.pc) begin
        failures++; $display("FAIL reset_post_pc[%0d] got=%h exp=%h", n, PC_out, e.pc);
      end
      checks++;
      if (ALUResult_out !== e.alu) begin
        failures++; $display("FAIL reset_post_alu[%0d] got=%h exp=%h", n, ALUResult_out, e.alu);
      end
      n++;
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    int n;
    prog = '{addi(1, 0, 7), addi(2, 0, 32'hFFFFFFFD),
             enc_r(7'h20, 2, 1, 3'b000, 3), enc_r(7'h00, 2, 1, 3'b010, 4),
             enc_r(7'h00, 2, 1, 3'b011, 4), addi(5, 0, 1),
             enc_r(7'h20, 5, 2, 3'b101, 2), enc_r(7'h00, 0, 3, 3'b000, 6),
             enc_r(7'h00, 2, 1, 3'b100, 7), enc_i(32'h004, 2, 3'b101, 7, 7'b0010011),
             enc_i(32'h003, 1, 3'b001, 7, 7'b0010011), enc_i(32'h401, 2, 3'b101, 7, 7'b0010011),
             enc_i(32'h000, 2, 3'b010, 7, 7'b0010011), enc_r(7'h00, 5, 1, 3'b110, 7),
             enc_r(7'h00, 1, 2, 3'b111, 7)};
    load_prog();
    @(negedge clk);
    apply_reset();
    push(32'h00, 32'h00000007); push(32'h04, 32'hFFFFFFFD); push(32'h08, 32'h0000000A);
    push(32'h0C, 32'h00000000); push(32'h10, 32'h00000001); push(32'h14, 32'h00000001);
    push(32'h18, 32'hFFFFFFFE); push(32'h1C, 32'h0000000A); push(32'h20, 32'hFFFFFFF9);
    push(32'h24, 32'h0FFFFFFF); push(32'h28, 32'h00000038); push(32'h2C, 32'hFFFFFFFF);
    push(32'h30, 32'h00000001); push(32'h34, 32'h00000007); push(32'h38, 32'h00000006);
    n = 0;
    while (exp_q.size() != 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (PC_out !== e.pc) begin
        failures++; $display("FAIL rtype_pc[%0d] got=%h exp=%h", n, PC_out, e.pc);
      end
      checks++;
      if (ALUResult_out !== e.alu) begin
        failures++; $display("FAIL rtype_alu[%0d] got=%h exp=%h", n, ALUResult_out, e.alu);
      end
      n++;
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

  task automatic test_memory();
    int n;
    prog = '{addi(1, 0, 32'h55), enc_s(32'h8, 1, 0),
             enc_i(32'h8, 0, 3'b010, 2, 7'b0000011), enc_r(7'h00, 0, 2, 3'b000, 3),
             addi(4, 0, 32'h66), enc_s(32'h10C, 4, 0),
             enc_i(32'hC, 0, 3'b010, 5, 7'b0000011), enc_r(7'h00, 0, 5, 3'b000, 6)};
    load_prog();
    @(negedge clk);
    apply_reset();
    push(32'h00, 32'h55); push(32'h04, 32'h08); push_m(32'h08, 32'h08, 32'h55);
    push(32'h0C, 32'h55); push(32'h10, 32'h66); push(32'h14, 32'h10C);
    push_m(32'h18, 32'h0C, 32'h66); push(32'h1C, 32'h66);
    n = 0;
    while (exp_q.size() != 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (PC_out !== e.pc) begin
        failures++; $display("FAIL mem_pc[%0d] got=%h exp=%h", n, PC_out, e.pc);
      end
      checks++;
      if (ALUResult_out !== e.alu) begin
        failures++; $display("FAIL mem_alu[%0d] got=%h exp=%h", n, ALUResult_out, e.alu);
      end
      if (e.chk_mem) begin
        checks++;
        if (Mem_ReadData_out !== e.mem) begin
          failures++; $display("FAIL mem_rdata[%0d] got=%h exp=%h", n, Mem_ReadData_out, e.mem);
        end
      end
      n++;
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

  task automatic test_control();
    int n;
    prog = '{addi(1, 0, 3), addi(2, 0, 3), enc_b(32'h8, 2, 1, 3'b000), addi(9, 0, 32'h99),
             enc_b(32'h8, 2, 1, 3'b001), enc_b(32'h10, 0, 1, 3'b000), addi(3, 0, 1),
             32'h0000_0013, enc_j(32'hC, 1), addi(10, 0, 32'hAA), addi(5, 0, 32'h28),
             enc_r(7'h00, 0, 1, 3'b000, 4), enc_b(32'hFFFFFFF8, 0, 4, 3'b001)};
    load_prog();
    @(negedge clk);
    apply_reset();
    push(32'h00, 32'h03); push(32'h04, 32'h03); push(32'h08, 32'h00); push(32'h10, 32'h00);
    push(32'h14, 32'h03); push(32'h18, 32'h01); push(32'h1C, 32'h00); push(32'h20, 32'h24);
    push(32'h2C, 32'h24); push(32'h30, 32'h24); push(32'h28, 32'h28); push(32'h2C, 32'h24);
    n = 0;
    while (exp_q.size() != 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (PC_out !== e.pc) begin
        failures++; $display("FAIL ctrl_pc[%0d] got=%h exp=%h", n, PC_out, e.pc);
      end
      checks++;
      if (ALUResult_out !== e.alu) begin
        failures++; $display("FAIL ctrl_alu[%0d] got=%h exp=%h", n, ALUResult_out, e.alu);
      end
      n++;
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

  task automatic test_x0_nop();
    int n;
    prog = '{addi(0, 0, 5), enc_r(7'h00, 0, 0, 3'b000, 1), addi(31, 0, 32'h77),
             32'hFFFF_FFFF, enc_r(7'h00, 0, 31, 3'b000, 2)};
    load_prog();
    @(negedge clk);
    apply_reset();
    push(32'h00, 32'h05); push(32'h04, 32'h00); push(32'h08, 32'h77);
    push(32'h0C, 32'h00); push(32'h10, 32'h77);
    n = 0;
    while (exp_q.size() != 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (PC_out !== e.pc) begin
        failures++; $display("FAIL x0nop_pc[%0d] got=%h exp=%h", n, PC_out, e.pc);
      end
      checks++;
      if (ALUResult_out !== e.alu) begin
        failures++; $display("FAIL x0nop_alu[%0d] got=%h exp=%h", n, ALUResult_out, e.alu);
      end
      n++;
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

  initial begin
    test_power_up();
    test_reset();
    test_rtype();
    test_memory();
    test_control();
    test_x0_nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
